// File: rtl/fir_bram_arbiter.sv
// Single-port BRAM arbiter shared by the FIR engine, stream-in writer and AXI-Lite config side.
// Define FIR_ARB_STARVE_GUARD_EN to add a starvation guard that force-grants a waiting config request.
module fir_bram_arbiter #(
    parameter int pADDR_WIDTH  = 12,
    parameter int pDATA_WIDTH  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   eng_req,
    input  logic                   eng_lock,
    input  logic [pADDR_WIDTH-1:0] eng_addr,
    input  logic                   sw_req,
    input  logic [pADDR_WIDTH-1:0] sw_addr,
    input  logic [pDATA_WIDTH-1:0] sw_wdata,
    input  logic                   cfg_req,
    input  logic                   cfg_we,
    input  logic [pADDR_WIDTH-1:0] cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    output logic                   eng_gnt,
    output logic                   sw_gnt,
    output logic                   cfg_gnt,
    output logic                   eng_rvalid,
    output logic                   cfg_rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ram_en,
    output logic [3:0]             ram_we,
    output logic [pADDR_WIDTH-1:0] ram_addr,
    output logic [pDATA_WIDTH-1:0] ram_di,
    input  logic [pDATA_WIDTH-1:0] ram_do
);

    typedef enum logic [1:0] {IDLE, ISSUE, LOCK} state_t;
    typedef enum logic [1:0] {WIN_NONE, WIN_ENG, WIN_SW, WIN_CFG} win_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_ENG, TAG_CFG} tag_t;

    state_t                 state, state_next;
    win_t                   win;
    tag_t                   tag;
    logic                   armed;
    logic                   locked;
    logic                   eng_ok, sw_ok, cfg_ok;
    logic                   force_cfg;
    logic [pDATA_WIDTH-1:0] rdata_q;

    // A requester is masked while its own grant is high; during a lock only the engine competes.
    always_comb begin
        locked = (state == LOCK) || (eng_lock && eng_req);
        eng_ok = eng_req && !eng_gnt;
        sw_ok  = sw_req  && !sw_gnt  && !locked;
        cfg_ok = cfg_req && !cfg_gnt && !locked;
    end

`ifdef FIR_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)
            starve_cnt <= '0;
        else if (!cfg_req || cfg_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign force_cfg = cfg_ok && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign force_cfg = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        win        = WIN_NONE;
        state_next = state;
        if (armed) begin
            if (force_cfg)   win = WIN_CFG;
            else if (eng_ok) win = WIN_ENG;
            else if (sw_ok)  win = WIN_SW;
            else if (cfg_ok) win = WIN_CFG;
        end
        if (eng_lock && eng_req)
            state_next = LOCK;
        else if (state == LOCK)
            state_next = eng_lock ? LOCK : IDLE;
        else
            state_next = (win != WIN_NONE) ? ISSUE : IDLE;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)
            state <= IDLE;
        else
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_next;
    end

    // armed stays low for the first edge after reset release, so the earliest grant lands on the second edge.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            armed      <= 1'b0;
            eng_gnt    <= 1'b0;
            sw_gnt     <= 1'b0;
            cfg_gnt    <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 4'h0;
            ram_addr   <= '0;
            ram_di     <= '0;
            tag        <= TAG_NONE;
            eng_rvalid <= 1'b0;
            cfg_rvalid <= 1'b0;
            rdata_q    <= '0;
        end else begin
            armed    <= 1'b1;
            eng_gnt  <= (win == WIN_ENG);
            sw_gnt   <= (win == WIN_SW);
            cfg_gnt  <= (win == WIN_CFG);
            ram_en   <= (win != WIN_NONE);
            ram_we   <= 4'h0;
            ram_addr <= '0;
            ram_di   <= '0;
            tag      <= TAG_NONE;
            case (win)
                WIN_ENG: begin
                    ram_addr <= eng_addr;
                    tag      <= TAG_ENG;
                end
                WIN_SW: begin
                    ram_addr <= sw_addr;
                    ram_we   <= 4'hF;
                    ram_di   <= sw_wdata;
                end
                WIN_CFG: begin
                    ram_addr <= cfg_addr;
                    if (cfg_we) begin
                        ram_we <= 4'hF;
                        ram_di <= cfg_wdata;
                    end else begin
                        tag <= TAG_CFG;
                    end
                end
                default: ;
            endcase
            eng_rvalid <= (tag == TAG_ENG);
            cfg_rvalid <= (tag == TAG_CFG);
            if (eng_rvalid || cfg_rvalid)
                rdata_q <= ram_do;
        end
    end

    // RAM output is only valid in the rvalid cycle, so pass it through then and hold it afterwards.
    assign rdata = (eng_rvalid || cfg_rvalid) ? ram_do : rdata_q;

endmodule
